// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bitrev_reorder
//  Purpose  : Reorders 64-point FFT output from bit-reversed to natural bin
//             order. Each frame is written into one bank of a two-bank
//             ping-pong store at its bit-reversed address, then replayed
//             sequentially as a contiguous N-cycle burst.
//  Ports    : clock         - single clock, rising edge
//             reset         - asynchronous, active-low
//             di_en/re/im   - input samples (bit-reversed order)
//             do_en/re/im   - output samples (natural order), zero when idle
//  Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int             N      = 1 << LOG2N;
    localparam logic [LOG2N-1:0] c_LAST = {LOG2N{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // Bank select is the address MSB: {bank, index}.
    logic [2*WIDTH-1:0] mem_q [0:2*N-1];

    logic [LOG2N-1:0]   wr_cnt_q;
    logic               wr_bank_q;
    logic [1:0]         full_q;
    logic [1:0]         full_d;
    state_t             state_q;
    logic [LOG2N-1:0]   rd_cnt_q;
    logic               rd_bank_q;
    logic               do_en_q;
    logic [WIDTH-1:0]   do_re_q;
    logic [WIDTH-1:0]   do_im_q;

    logic [LOG2N-1:0]   w_wr_addr;
    logic               w_wr_last;
    logic               w_rd_last;
    logic               w_other_full;
    logic [2*WIDTH-1:0] w_rd_word;

    for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
        assign w_wr_addr[i] = wr_cnt_q[LOG2N-1-i];
    end

    assign w_wr_last = di_en && (wr_cnt_q == c_LAST);
    assign w_rd_last = (state_q == ST_READ) && (rd_cnt_q == c_LAST);
    assign w_rd_word = mem_q[{rd_bank_q, rd_cnt_q}];

    // The next bank counts as ready if it was already full or its final
    // sample lands on this same edge; this keeps back-to-back bursts gap-free.
    assign w_other_full = full_q[~rd_bank_q] || (w_wr_last && (wr_bank_q != rd_bank_q));

    // Storage carries no reset; stale contents are never read because the
    // full flags gate readout.
    always_ff @(posedge clock) begin
        if (di_en) begin
            mem_q[{wr_bank_q, w_wr_addr}] <= {di_re, di_im};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (di_en) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;  // wraps to 0 after N-1
            if (w_wr_last) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    // Set and clear never target the same bank on one edge, so order is moot.
    always_comb begin
        full_d = full_q;
        if (w_rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (w_wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            do_en_q   <= 1'b0;
            do_re_q   <= '0;
            do_im_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    do_en_q <= 1'b0;
                    do_re_q <= '0;
                    do_im_q <= '0;
                    if (full_q[rd_bank_q]) begin
                        state_q  <= ST_READ;
                        rd_cnt_q <= '0;
                    end
                end
                ST_READ: begin
                    do_en_q              <= 1'b1;
                    {do_re_q, do_im_q}   <= w_rd_word;
                    rd_cnt_q             <= rd_cnt_q + 1'b1;
                    if (rd_cnt_q == c_LAST) begin
                        rd_bank_q <= ~rd_bank_q;
                        if (!w_other_full) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    do_en_q <= 1'b0;
                    do_re_q <= '0;
                    do_im_q <= '0;
                end
            endcase
        end
    end

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_bitrev_reorder
//  Purpose  : Self-checking bench for fft_bitrev_reorder. Frames are described
//             in a table of {input tags, expected natural-order base values};
//             expected outputs go to a scoreboard queue and are compared as
//             the DUT emits them.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

    localparam int WIDTH = 16;
    localparam int LOG2N = 6;
    localparam int N     = 64;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             di_en = 1'b0;
    logic [WIDTH-1:0] di_re = '0;
    logic [WIDTH-1:0] di_im = '0;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb [$];
    int run      = 0;
    int last_run = 0;
    int bursts   = 0;

    typedef struct {
        logic [7:0]  tag_re;
        logic [7:0]  tag_im;
        bit          gap;
        logic [15:0] exp_re0;
        logic [15:0] exp_im0;
    } vec_t;

    vec_t tbl [8];

    fft_bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] bitrev6(input logic [5:0] x);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = x[5-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clock) begin
        if (!reset) begin
            run = 0;
            check("reset_outputs", {15'd0, do_en, do_re, do_im}, 48'd0);
        end else if (do_en) begin
            run++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got re=%0h im=%0h expected no output at %0t",
                         do_re, do_im, $time);
            end else begin
                check("data", {16'd0, do_re, do_im}, {16'd0, sb.pop_front()});
            end
        end else begin
            check("idle_zero", {16'd0, do_re, do_im}, 48'd0);
            if (run > 0) begin
                bursts++;
                last_run = run;
                check("burst_len_mod64", 48'(run % N), 48'd0);
                run = 0;
            end
        end
    end

    task automatic send_frame(input vec_t v);
        for (int n = 0; n < N; n++) begin
            if (v.gap) begin
                @(negedge clock);
                di_en = 1'b0;
                di_re = 16'($urandom);
                di_im = 16'($urandom);
            end
            @(negedge clock);
            di_en = 1'b1;
            di_re = {v.tag_re, 2'b00, bitrev6(6'(n))};
            di_im = {v.tag_im, 2'b00, bitrev6(6'(n))};
        end
        for (int k = 0; k < N; k++) begin
            sb.push_back({v.exp_re0 + 16'(k), v.exp_im0 + 16'(k)});
        end
    endtask

    task automatic send_partial(input int cnt);
        for (int n = 0; n < cnt; n++) begin
            @(negedge clock);
            di_en = 1'b1;
            di_re = {8'hEE, 2'b00, bitrev6(6'(n))};
            di_im = {8'hEF, 2'b00, bitrev6(6'(n))};
        end
    endtask

    task automatic drain(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0 && !do_en) break;
        end
        if (i == limit) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int i;
        tbl[0] = '{8'h00, 8'h10, 1'b0, 16'h0000, 16'h1000};
        tbl[1] = '{8'h01, 8'h11, 1'b0, 16'h0100, 16'h1100};
        tbl[2] = '{8'h02, 8'h12, 1'b0, 16'h0200, 16'h1200};
        tbl[3] = '{8'h03, 8'h13, 1'b0, 16'h0300, 16'h1300};
        tbl[4] = '{8'h04, 8'h14, 1'b1, 16'h0400, 16'h1400};
        tbl[5] = '{8'h05, 8'h15, 1'b0, 16'h0500, 16'h1500};
        tbl[6] = '{8'h06, 8'h16, 1'b0, 16'h0600, 16'h1600};
        tbl[7] = '{8'h07, 8'h17, 1'b0, 16'h0700, 16'h1700};

        // Reset held with random inputs.
        #1;
        check("reset_async", {15'd0, do_en, do_re, do_im}, 48'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            di_en = 1'($urandom_range(0, 1));
            di_re = 16'($urandom);
            di_im = 16'($urandom);
            check("reset_hold", {15'd0, do_en, do_re, do_im}, 48'd0);
        end
        @(negedge clock);
        di_en = 1'b0;
        #2 reset = 1'b1;

        // Single frame with latency check.
        send_frame(tbl[0]);
        @(negedge clock);
        di_en = 1'b0;
        check("lat_e0", {47'd0, do_en}, 48'd0);
        @(negedge clock);
        check("lat_e1", {47'd0, do_en}, 48'd0);
        @(negedge clock);
        check("lat_e2", {47'd0, do_en}, 48'd1);
        drain("single", 200);
        check("single_len", 48'(last_run), 48'd64);

        // Three back-to-back frames.
        b0 = bursts;
        for (int f = 1; f <= 3; f++) send_frame(tbl[f]);
        @(negedge clock);
        di_en = 1'b0;
        drain("b2b", 400);
        check("b2b_len", 48'(last_run), 48'd192);
        check("b2b_bursts", 48'(bursts - b0), 48'd1);

        // Gapped input.
        b0 = bursts;
        send_frame(tbl[4]);
        @(negedge clock);
        di_en = 1'b0;
        drain("gapped", 200);
        check("gapped_len", 48'(last_run), 48'd64);
        check("gapped_bursts", 48'(bursts - b0), 48'd1);

        // Reset in the middle of writing a frame.
        send_partial(30);
        @(negedge clock);
        di_en = 1'b0;
        #2 reset = 1'b0;
        #1 check("rst_midwrite", {15'd0, do_en, do_re, do_im}, 48'd0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        b0 = bursts;
        send_frame(tbl[5]);
        @(negedge clock);
        di_en = 1'b0;
        drain("midwrite", 200);
        check("midwrite_len", 48'(last_run), 48'd64);
        check("midwrite_bursts", 48'(bursts - b0), 48'd1);

        // Reset during output bin 20.
        send_frame(tbl[6]);
        @(negedge clock);
        di_en = 1'b0;
        for (i = 0; i < 200; i++) begin
            @(negedge clock);
            if (do_en && do_re[5:0] == 6'd20) break;
        end
        if (i == 200) begin
            total++;
            bad++;
            $display("FAIL midread_wait: got no bin 20 expected bin 20");
        end
        #2 reset = 1'b0;
        #1 check("rst_midread", {15'd0, do_en, do_re, do_im}, 48'd0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        b0 = bursts;
        repeat (100) @(negedge clock);
        #1 check("midread_quiet", 48'(bursts - b0), 48'd0);
        send_frame(tbl[7]);
        @(negedge clock);
        di_en = 1'b0;
        drain("midread", 200);
        check("midread_len", 48'(last_run), 48'd64);
        check("midread_bursts", 48'(bursts - b0), 48'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder stage placed directly downstream of the 64-point `FFT` core. The core emits each frame's bins in bit-reversed index order on `do_en/do_re/do_im`. This block buffers one frame per bank in a two-bank ping-pong store and replays it in natural bin order (0..N-1) as a contiguous burst. This removes the software bit-reversal currently done at capture time.

## Interface
- `WIDTH`, 16, bit width of each real/imag component
- `LOG2N`, 6, log2 of frame length; N = 2^LOG2N = 64

- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset; asserted when 0
- `di_en`  in  1  input sample valid; driven by FFT `do_en`
- `di_re`  in  WIDTH  input real part, bit-reversed order; sampled only when `di_en`=1
- `di_im`  in  WIDTH  input imag part; sampled only when `di_en`=1
- `do_en`  out  1  output sample valid
- `do_re`  out  WIDTH  output real part, natural order
- `do_im`  out  WIDTH  output imag part, natural order

## Operation
- Storage is 2 banks × N entries × 2·WIDTH bits. `wr_bank` and `rd_bank` are 1-bit bank pointers. Each bank carries a `full` flag.
- **Write side:** the LOG2N-bit `wr_cnt` counts accepted samples. On a rising edge with `di_en`=1:
  - store {di_re, di_im} into bank[`wr_bank`] at address bitrev(`wr_cnt`);
  - increment `wr_cnt`.
- `di_en` may drop mid-frame. `wr_cnt` holds during gaps; there is no timeout.
- When the sample with `wr_cnt`=N-1 is written:
  - set full[`wr_bank`];
  - toggle `wr_bank`;
  - wrap `wr_cnt` to 0.
- Input arrives at no more than 1 sample/cycle and readout runs at exactly 1 sample/cycle. By construction the write side therefore never targets a full bank. Writes are not gated by `full`.
- **Read FSM:**
  - IDLE: if full[`rd_bank`], go to READ with `rd_cnt`=0.
  - READ: each cycle, register bank[`rd_bank`][`rd_cnt`] onto `do_re/do_im` with `do_en`=1, then increment `rd_cnt`.
  - On the read of `rd_cnt`=N-1: clear full[`rd_bank`] and toggle `rd_bank`. If the other bank is already full (or becomes full on this same edge), stay in READ with `rd_cnt`=0. Otherwise go to IDLE.
- **Simultaneous events:**
  - Final write into bank X and final read from bank Y≠X on the same edge: both take effect, and the burst continues gap-free.
  - Set and clear of the same bank's `full` on the same edge cannot occur.
- `do_re`/`do_im` are forced to 0 whenever `do_en`=0.
- No arithmetic is performed; data passes bit-exact.

## Timing
- **Reset values** (immediate on `reset`=0, independent of clock):
  - `do_en`=0, `do_re`=0, `do_im`=0;
  - `wr_cnt`=0, `rd_cnt`=0, `wr_bank`=0, `rd_bank`=0;
  - both `full`=0; FSM in IDLE.
- Buffer contents need no reset. Any partial or pending frame is discarded.
- Latency: let edge E0 accept the frame's last input sample.
  - E1: FSM enters READ.
  - E2: first output (bin 0) appears, `do_en`=1.
  - `do_en` stays high for exactly N consecutive cycles per frame (bins 0..N-1).
- Back-to-back input frames produce back-to-back output bursts with no idle cycle between them.
- Reset deasserting mid-stream: the first sample accepted afterwards is treated as bit-reversed index 0.

## Test plan
- **Reset:** hold `reset`=0 for 5 cycles with random `di_*`. Expect `do_en`=0 and `do_re`=`do_im`=0 throughout; no output after release until 64 samples are accepted.
- **Single frame:** feed n=0..63 with `di_re`=bitrev6(n), `di_im`=16'h1000+bitrev6(n). Expect `do_en`=1 starting 2 cycles after the last input, for 64 cycles. Expect `do_re`=0..63 and `do_im`=16'h1000..16'h103F in order, with `do_en`=0 afterwards.
- **Three back-to-back frames** (192 consecutive `di_en` cycles, frame index in bits 15:8). Expect 192 consecutive `do_en` cycles with no gap, each frame in natural order, frames in arrival order.
- **Gapped input:** `di_en` toggles every other cycle for one frame. Expect no `do_en` before the 64th accepted sample; then a contiguous 64-cycle burst with correct order.
- **Reset mid-write:** assert `reset` after 30 samples, release, then send one full frame. Expect exactly one 64-sample burst containing only the new frame.
- **Reset mid-read:** assert `reset` during output bin 20. Expect `do_en`=0 and data 0 immediately; no further output until a new frame completes.
